imem_arbiter: RTL and testbench

//   Shares the single-port synchronous instruction RAM between two requesters:
//   the CPU fetch stage (read-only) and the program loader (read/write, used
//   for boot load and debug readback). Sits between the fetch stage, the

---
 rtl/imem_arbiter_if.sv | 51 +++++
 rtl/imem_arbiter.sv | 145 ++++++++++++++
 tb/tb_imem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader, the RAM macro and
// the instruction-memory arbiter.
//   fetch_*   : fetch read requests and responses
//   ld_*      : loader read/write requests and read responses
//   mem_*     : single-port synchronous RAM drive and read data
// Modports:
//   slave  : the arbiter's view (takes requests and RAM data, drives grants,
//            responses and the RAM controls)
//   master : the surrounding environment's view (requesters plus RAM)
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction RAM arbiter: shares one single-port synchronous RAM between the
// CPU fetch stage (read-only) and the program loader (read/write). One access
// is granted per cycle; each 1-cycle-latency read response is steered back to
// the requester that issued it.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : imem_arbiter_if.slave (fetch, loader and RAM signals)
// Grants and RAM drive are combinational from the requests and the state.
// Build option IMEM_ARB_STARVE_GUARD_EN: when defined, a fetch that has been
// denied MAX_WAIT consecutive cycles wins over the loader for one cycle.
// Otherwise the loader has strict priority.
module imem_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESP_FETCH = 2'd1,
        RESP_LD    = 2'd2
    } state_t;

    // The starvation guard is meaningless without at least one denied cycle.
    if (MAX_WAIT < 1) begin : g_max_wait_chk
        $error("imem_arbiter: MAX_WAIT must be at least 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic              force_fetch;

    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    // Count consecutive denied fetch cycles, saturating at WAIT_MAX.
    always_comb begin
        wait_d = '0;
        if (bus.fetch_req && !fetch_gnt) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign force_fetch = (wait_q == WAIT_MAX) && bus.fetch_req;
`else
    assign force_fetch = 1'b0;
`endif

    // Response owner register; an in-flight response is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, RAM drive, next owner and response routing.
    always_comb begin
        fetch_gnt    = 1'b0;
        ld_gnt       = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        state_d      = IDLE;
        fetch_rvalid = 1'b0;
        fetch_rdata  = '0;
        ld_rvalid    = 1'b0;
        ld_rdata     = '0;

        // Loader wins unless the starvation guard forces the fetch through.
        if (!rst) begin
            if (bus.ld_req && !force_fetch) begin
                ld_gnt = 1'b1;
            end else if (bus.fetch_req) begin
                fetch_gnt = 1'b1;
            end
        end

        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = bus.ld_we;
            mem_addr  = bus.ld_addr;
            mem_wdata = bus.ld_we ? bus.ld_wdata : '0;
            state_d   = bus.ld_we ? IDLE : RESP_LD;
        end else if (fetch_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = bus.fetch_addr;
            state_d   = RESP_FETCH;
        end

        case (state_q)
            RESP_FETCH: begin
                fetch_rvalid = 1'b1;
                fetch_rdata  = bus.mem_rdata;
            end
            RESP_LD: begin
                ld_rvalid = 1'b1;
                ld_rdata  = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.fetch_rdata  = fetch_rdata;
    assign bus.ld_gnt       = ld_gnt;
    assign bus.ld_rvalid    = ld_rvalid;
    assign bus.ld_rdata     = ld_rdata;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter. The driver pushes the hand-computed
// grant/RAM-drive expectation for every cycle and the expected read data with
// the cycle it must arrive in; a negedge monitor pops and compares.
// The RAM macro is a behavioural write-first, 1-cycle-latency array whose
// word at address a is preloaded with 32'hA000_0000 | a.
module tb_imem_arbiter;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              fg;
        logic              lg;
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    gnt_exp_t gq[$];
    rsp_exp_t fq[$];
    rsp_exp_t lq[$];

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first single-port RAM model.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                bus.mem_rdata     <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: grants and RAM drive every driven cycle, responses on their due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (gq.size() > 0) begin
                gnt_exp_t e;
                e = gq.pop_front();
                check("fetch_gnt", 64'(bus.fetch_gnt), 64'(e.fg));
                check("ld_gnt",    64'(bus.ld_gnt),    64'(e.lg));
                check("mem_en",    64'(bus.mem_en),    64'(e.en));
                check("mem_we",    64'(bus.mem_we),    64'(e.we));
                check("mem_addr",  64'(bus.mem_addr),  64'(e.addr));
                check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
            end
            if (fq.size() > 0 && fq[0].due == cyc) begin
                rsp_exp_t r;
                r = fq.pop_front();
                check("fetch_rvalid", 64'(bus.fetch_rvalid), 64'd1);
                check("fetch_rdata",  64'(bus.fetch_rdata),  64'(r.data));
            end else begin
                check("fetch_rvalid_idle", 64'(bus.fetch_rvalid), 64'd0);
                check("fetch_rdata_idle",  64'(bus.fetch_rdata),  64'd0);
            end
            if (lq.size() > 0 && lq[0].due == cyc) begin
                rsp_exp_t r;
                r = lq.pop_front();
                check("ld_rvalid", 64'(bus.ld_rvalid), 64'd1);
                check("ld_rdata",  64'(bus.ld_rdata),  64'(r.data));
            end else begin
                check("ld_rvalid_idle", 64'(bus.ld_rvalid), 64'd0);
                check("ld_rdata_idle",  64'(bus.ld_rdata),  64'd0);
            end
        end
    end

    // Drive one cycle's requests now and queue the expected grant and response.
    task automatic drive_now(input logic fr, input logic [ADDR_W-1:0] fa,
                             input logic lr, input logic lwe,
                             input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] lwd,
                             input logic efg, input logic elg,
                             input logic [DATA_W-1:0] edata, input bit push_rsp);
        gnt_exp_t e;
        rsp_exp_t r;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.ld_req     = lr;
        bus.ld_we      = lwe;
        bus.ld_addr    = la;
        bus.ld_wdata   = lwd;
        e.fg    = efg;
        e.lg    = elg;
        e.en    = efg | elg;
        e.we    = elg & lwe;
        e.addr  = elg ? la : (efg ? fa : '0);
        e.wdata = (elg & lwe) ? lwd : '0;
        gq.push_back(e);
        if (push_rsp) begin
            r.due  = cyc + 1;
            r.data = edata;
            if (efg) fq.push_back(r);
            else if (elg && !lwe) lq.push_back(r);
        end
    endtask

    task automatic cycle(input logic fr, input logic [ADDR_W-1:0] fa,
                         input logic lr, input logic lwe,
                         input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] lwd,
                         input logic efg, input logic elg,
                         input logic [DATA_W-1:0] edata);
        @(posedge clk);
        #1;
        drive_now(fr, fa, lr, lwe, la, lwd, efg, elg, edata, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fetch_gnt"},    64'(bus.fetch_gnt),    64'd0);
        check({tag, "_ld_gnt"},       64'(bus.ld_gnt),       64'd0);
        check({tag, "_fetch_rvalid"}, 64'(bus.fetch_rvalid), 64'd0);
        check({tag, "_ld_rvalid"},    64'(bus.ld_rvalid),    64'd0);
        check({tag, "_mem_en"},       64'(bus.mem_en),       64'd0);
        check({tag, "_mem_we"},       64'(bus.mem_we),       64'd0);
        check({tag, "_mem_addr"},     64'(bus.mem_addr),     64'd0);
        check({tag, "_mem_wdata"},    64'(bus.mem_wdata),    64'd0);
        check({tag, "_fetch_rdata"},  64'(bus.fetch_rdata),  64'd0);
        check({tag, "_ld_rdata"},     64'(bus.ld_rdata),     64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hA000_0000 | 32'(i);
        bus.mem_rdata  = '0;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 12'h00F;
        bus.ld_req     = 1'b1;
        bus.ld_we      = 1'b1;
        bus.ld_addr    = 12'h00F;
        bus.ld_wdata   = 32'h1111_1111;

        // Reset state with both requesters asserting.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");

        // 1: fetch-only burst at 0..3, first grant right after reset release.
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_now(1'b1, 12'h000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0000, 1'b1);
        cycle(1'b1, 12'h001, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0001);
        cycle(1'b1, 12'h002, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0002);
        cycle(1'b1, 12'h003, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0003);
        idle();

        // 2: loader write then read-back, then fetch sees the new word.
        cycle(1'b0, '0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 1'b1, '0);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cycle(1'b1, 12'h010, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        idle();

        // 3/4: both request for 10 cycles; denied requesters hold their address.
        k = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
            if (i == 4 || i == 9) begin
                cycle(1'b1, 12'h100, 1'b1, 1'b0, 12'(12'h020 + k), '0, 1'b1, 1'b0, 32'hA000_0100);
            end else begin
                cycle(1'b1, 12'h100, 1'b1, 1'b0, 12'(12'h020 + k), '0, 1'b0, 1'b1,
                      32'hA000_0020 + 32'(k));
                k++;
            end
`else
            cycle(1'b1, 12'h100, 1'b1, 1'b0, 12'(12'h020 + k), '0, 1'b0, 1'b1,
                  32'hA000_0020 + 32'(k));
            k++;
`endif
        end
        idle();

        // 6: alternating owners at both ends of the address range.
        cycle(1'b1, 12'h000, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0000);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'hFFF, '0, 1'b0, 1'b1, 32'hA000_0FFF);
        cycle(1'b1, 12'hFFF, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0FFF);
        cycle(1'b0, '0, 1'b1, 1'b0, 12'h000, '0, 1'b0, 1'b1, 32'hA000_0000);
        cycle(1'b0, '0, 1'b1, 1'b1, 12'hFFF, 32'h1234_5678, 1'b0, 1'b1, '0);
        cycle(1'b1, 12'hFFF, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1234_5678);
        idle();

        // 5: reset pulsed mid-cycle while a fetch read is in flight.
        @(posedge clk);
        #1;
        drive_now(1'b1, 12'h005, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        check_all_zero("held_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_now(1'b1, 12'h006, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA000_0006, 1'b1);
        idle();
        idle();
        @(negedge clk);
        #1;

        check("fetch_rsp_outstanding", 64'(fq.size()), 64'd0);
        check("ld_rsp_outstanding",    64'(lq.size()), 64'd0);
        check("gnt_exp_outstanding",   64'(gq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
